// File: rtl/memory_ports_pkg.sv
// Shared types for memory_ports: clear-FSM state, the max-width word container
// and the byte-to-bit mask expansion used by both the write path and the bypass merge.
package memory_ports_pkg;

  localparam int MAX_BYTES = 64;

  typedef logic [MAX_BYTES*8-1:0] mem_word_t;

  typedef enum logic {
    MEM_CLEAR,
    MEM_READY
  } mem_state_e;

  function automatic mem_word_t byte_mask_expand(input logic [MAX_BYTES-1:0] mask);
    mem_word_t bits;
    for (int i = 0; i < MAX_BYTES; i++) bits[8*i +: 8] = {8{mask[i]}};
    return bits;
  endfunction

endpackage

// File: rtl/memory_read_pipe.sv
// Per-port read latency pipe: valid and data shifted together, synchronous clear.
// LATENCY = 0 is a straight combinational pass-through.
module memory_read_pipe #(
  parameter int DW      = 64,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_in,
  input  logic [DW-1:0] data_in,
  output logic          vld_out,
  output logic [DW-1:0] data_out
);

  if (LATENCY == 0) begin : g_comb
    logic unused_clk;
    assign unused_clk = clk ^ reset;
    assign vld_out    = vld_in;
    assign data_out   = data_in;
  end else begin : g_reg
    logic [LATENCY-1:0]         vld_pipe_d, vld_pipe_q;
    logic [LATENCY-1:0][DW-1:0] data_pipe_d, data_pipe_q;

    // A stage only reloads data when a valid word arrives, so the output holds between reads.
    always_comb begin
      vld_pipe_d     = '0;
      data_pipe_d    = data_pipe_q;
      vld_pipe_d[0]  = vld_in;
      if (vld_in) data_pipe_d[0] = data_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        if (vld_pipe_q[i-1]) data_pipe_d[i] = data_pipe_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pipe_q  <= '0;
        data_pipe_q <= '0;
      end else begin
        vld_pipe_q  <= vld_pipe_d;
        data_pipe_q <= data_pipe_d;
      end
    end

    assign vld_out  = vld_pipe_q[LATENCY-1];
    assign data_out = data_pipe_q[LATENCY-1];
  end

endmodule

// File: rtl/memory_ports.sv
// Byte-masked memory with one write port and READ_PORTS read ports, zero-cleared after reset.
// MEMORY_PORTS_BYPASS_EN selects write-first for same-address read/write (latency >= 1).
module memory_ports
  import memory_ports_pkg::*;
#(
  parameter int MEM_WIDTH_BYTES = 8,
  parameter int MEM_DEPTH       = 256,
  parameter int READ_PORTS      = 2,
  parameter int READ_LATENCY    = 1,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int DW = MEM_WIDTH_BYTES * 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                write_in,
  input  logic [AW-1:0]                       write_addr_in,
  input  logic [DW-1:0]                       write_data_in,
  input  logic [MEM_WIDTH_BYTES-1:0]          write_mask_in,
  input  logic [READ_PORTS-1:0]               read_in,
  input  logic [READ_PORTS-1:0][AW-1:0]       read_addr_in,
  output logic [READ_PORTS-1:0][DW-1:0]       read_data_out,
  output logic [READ_PORTS-1:0]               read_valid_out,
  output logic                                busy_out,
  input  logic                                debugen_in
);

  mem_state_e    state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;
  logic          wr_en;
  logic [DW-1:0] wmask_bits;
  logic [DW-1:0] mem_q [MEM_DEPTH];
  logic          debugen_unused;

  assign debugen_unused = debugen_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == MEM_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(MEM_DEPTH - 1)) state_d = MEM_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_out   = (state_q == MEM_CLEAR);
  assign wr_en      = write_in && !busy_out;
  assign wmask_bits = DW'(byte_mask_expand(MAX_BYTES'(write_mask_in)));

  // The clear sequence owns the write port until READY; user writes are dropped meanwhile.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy_out)
        mem_q[cnt_q] <= '0;
      else if (wr_en)
        mem_q[write_addr_in] <= (mem_q[write_addr_in] & ~wmask_bits)
                              | (write_data_in & wmask_bits);
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [DW-1:0] old_word, rd_word;
    assign old_word = mem_q[read_addr_in[p]];

    if (READ_LATENCY > 0) begin : g_lat
`ifdef MEMORY_PORTS_BYPASS_EN
      assign rd_word = (wr_en && (write_addr_in == read_addr_in[p]))
                     ? ((old_word & ~wmask_bits) | (write_data_in & wmask_bits))
                     : old_word;
`else
      assign rd_word = old_word;
`endif
    end else begin : g_show_ahead
      assign rd_word = old_word;
    end

    memory_read_pipe #(
      .DW      (DW),
      .LATENCY (READ_LATENCY)
    ) u_pipe (
      .clk      (clk),
      .reset    (reset),
      .vld_in   (read_in[p] && !busy_out),
      .data_in  (rd_word),
      .vld_out  (read_valid_out[p]),
      .data_out (read_data_out[p])
    );
  end

endmodule

// File: tb/tb_memory_ports.sv
// Randomized bench for memory_ports: scoreboard of issued reads against an array model of the memory.
module tb_memory_ports;

  localparam int BYTES = 8;
  localparam int DEPTH = 16;
  localparam int PORTS = 2;
  localparam int LAT   = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   write_in = 1'b0;
  logic [3:0]             write_addr_in = '0;
  logic [63:0]            write_data_in = '0;
  logic [7:0]             write_mask_in = '0;
  logic [PORTS-1:0]       read_in = '0;
  logic [PORTS-1:0][3:0]  read_addr_in = '0;
  logic [PORTS-1:0][63:0] read_data_out;
  logic [PORTS-1:0]       read_valid_out;
  logic                   busy_out;

  memory_ports #(
    .MEM_WIDTH_BYTES (BYTES),
    .MEM_DEPTH       (DEPTH),
    .READ_PORTS      (PORTS),
    .READ_LATENCY    (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .write_in       (write_in),
    .write_addr_in  (write_addr_in),
    .write_data_in  (write_data_in),
    .write_mask_in  (write_mask_in),
    .read_in        (read_in),
    .read_addr_in   (read_addr_in),
    .read_data_out  (read_data_out),
    .read_valid_out (read_valid_out),
    .busy_out       (busy_out),
    .debugen_in     (1'b0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] data;
  } rd_t;

  logic [63:0] model [DEPTH];
  rd_t         rq [PORTS][$];
  logic [63:0] last [PORTS];
  int          cyc = 0;
  int          clr_left = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] w = old;
    for (int b = 0; b < 8; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  task automatic check_outputs();
    chk("busy", {63'd0, busy_out}, {63'd0, clr_left > 0});
    for (int p = 0; p < PORTS; p++) begin
      if (rq[p].size() > 0 && rq[p][0].due == cyc) begin
        chk($sformatf("valid%0d", p), {63'd0, read_valid_out[p]}, 64'd1);
        chk($sformatf("data%0d", p), read_data_out[p], rq[p][0].data);
        last[p] = rq[p][0].data;
        void'(rq[p].pop_front());
      end else begin
        chk($sformatf("idle_valid%0d", p), {63'd0, read_valid_out[p]}, 64'd0);
        chk($sformatf("hold_data%0d", p), read_data_out[p], last[p]);
      end
    end
  endtask

  task automatic do_cycle(input logic wr, input logic [3:0] wa, input logic [63:0] wd,
                          input logic [7:0] wm, input logic [1:0] rd,
                          input logic [3:0] ra0, input logic [3:0] ra1);
    logic [3:0]  ra [PORTS];
    logic [63:0] w;
    ra[0] = ra0;
    ra[1] = ra1;
    write_in        = wr;
    write_addr_in   = wa;
    write_data_in   = wd;
    write_mask_in   = wm;
    read_in         = rd;
    read_addr_in[0] = ra0;
    read_addr_in[1] = ra1;
    if (clr_left == 0) begin
      for (int p = 0; p < PORTS; p++) begin
        if (rd[p]) begin
          w = model[ra[p]];
`ifdef MEMORY_PORTS_BYPASS_EN
          if (wr && wa == ra[p]) w = merge(w, wd, wm);
`endif
          rq[p].push_back('{due: cyc + LAT, data: w});
        end
      end
    end
    @(posedge clk);
    cyc++;
    if (clr_left > 0) clr_left--;
    else if (wr) model[wa] = merge(model[wa], wd, wm);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic [1:0] rd_during);
    write_in = 1'b0;
    read_in  = rd_during;
    reset    = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      rq[p].delete();
      last[p] = '0;
    end
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    clr_left = DEPTH;
    chk("rst_busy", {63'd0, busy_out}, 64'd1);
    chk("rst_valid", {62'd0, read_valid_out}, 64'd0);
    for (int p = 0; p < PORTS; p++) chk($sformatf("rst_data%0d", p), read_data_out[p], 64'd0);
  endtask

  initial begin
    do_reset(2'b00);

    // Clear phase: stray write to address 2 and reads must be ignored.
    for (int i = 0; i < DEPTH; i++)
      do_cycle(1'b1, 4'd2, 64'hFF, 8'hFF, 2'b11, 4'(i), 4'd2);
    chk("clear_done", {63'd0, busy_out}, 64'd0);

    for (int a = 0; a < DEPTH; a++)
      do_cycle(1'b0, '0, '0, '0, 2'b11, 4'(a), 4'(DEPTH - 1 - a));

    do_cycle(1'b1, 4'd3, 64'h1122334455667788, 8'hFF, 2'b00, '0, '0);
    do_cycle(1'b1, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 2'b00, '0, '0);
    do_cycle(1'b0, '0, '0, '0, 2'b11, 4'd3, 4'd3);
    do_cycle(1'b0, '0, '0, '0, 2'b00, '0, '0);
    do_cycle(1'b0, '0, '0, '0, 2'b00, '0, '0);
    chk("masked_word", last[0], 64'h11223344AAAAAAAA);
    chk("dual_same", last[1], 64'h11223344AAAAAAAA);

    do_cycle(1'b1, 4'd5, 64'h55, 8'h01, 2'b01, 4'd5, '0);
    do_cycle(1'b0, '0, '0, '0, 2'b00, '0, '0);
    do_cycle(1'b0, '0, '0, '0, 2'b00, '0, '0);
`ifdef MEMORY_PORTS_BYPASS_EN
    chk("collision", last[0], 64'h55);
`else
    chk("collision", last[0], 64'h0);
`endif

    for (int i = 0; i < 300; i++)
      do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)),
               {$urandom, $urandom}, 8'($urandom), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, DEPTH - 1)));

    // Reads in flight when reset hits must never produce a valid.
    do_cycle(1'b0, '0, '0, '0, 2'b11, 4'd3, 4'd7);
    do_reset(2'b11);
    for (int i = 0; i < DEPTH; i++)
      do_cycle(1'b0, '0, '0, '0, 2'b11, 4'd3, 4'd5);
    for (int i = 0; i < 4; i++)
      do_cycle(1'b0, '0, '0, '0, 2'b11, 4'd3, 4'(i));
    for (int i = 0; i < LAT + 1; i++)
      do_cycle(1'b0, '0, '0, '0, 2'b00, '0, '0);
    chk("post_reset_zero", last[0], 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
